// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the synchronous FIFO. Issues read strobes against a
// credit count, catches the one-cycle read data in a 2-entry skid buffer, streams it out.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  m_count,
   output logic                  err_underflow
);

   logic [1:0][FIFO_WIDTH-1:0] skid_mem;
   logic                       head;
   logic                       tail;
   logic                       inflight;
   logic [1:0]                 cnt;
   logic                       pop;
   logic [2:0]                 occ_nxt;

   assign m_valid = (cnt != 2'd0);
   assign m_data  = m_valid ? skid_mem[head] : '0;
   assign pop     = m_valid && m_ready;

   // Occupancy after this edge; a word in flight already owns a slot, so reads are
   // only issued while that total stays below two.
   assign occ_nxt    = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = rst_n && drain_en && !fifo_empty && (occ_nxt < 3'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skid_mem      <= '0;
         head          <= 1'b0;
         tail          <= 1'b0;
         inflight      <= 1'b0;
         cnt           <= 2'd0;
         m_count       <= '0;
         err_underflow <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         // Read data is presented the cycle after the strobe and lands at this edge.
         if (inflight) begin
            skid_mem[tail] <= fifo_data_out;
            tail           <= ~tail;
         end
         if (pop) begin
            head    <= ~head;
            m_count <= m_count + CNT_WIDTH'(1);
         end
         cnt <= occ_nxt[1:0];
         if (fifo_underflow)
            err_underflow <= 1'b1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) occ_nxt <= 3'd2)
      else $error("fifo_rd_stream: skid buffer occupancy exceeded 2");

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with one-cycle read latency, scoreboard
// of loaded words compared at every stream handshake, plus a narrow-counter instance.
module tb_fifo_rd_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        drain_en;
   logic [15:0] fifo_data_out;
   logic        fifo_empty;
   logic        fifo_underflow;
   logic        fifo_rd_en;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ready;
   logic [15:0] m_count;
   logic        err_underflow;

   logic        rd_en4, m_valid4, err4;
   logic [15:0] m_data4;
   logic [3:0]  m_count4;

   logic [15:0] mem [0:255];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   logic [15:0] exp_q [$];
   int unsigned exp_cnt = 0;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .fifo_data_out(fifo_data_out),
      .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_count(m_count),
      .err_underflow(err_underflow));

   fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .fifo_data_out(fifo_data_out),
      .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_rd_en(rd_en4),
      .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .m_count(m_count4),
      .err_underflow(err4));

   // FIFO model: data follows the strobe by one cycle, flushed by the shared reset.
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr        <= wr_ptr;
         fifo_data_out <= '0;
      end else if (fifo_rd_en) begin
         fifo_data_out <= mem[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_cnt = 0;
      end else if (m_valid === 1'b1 && m_ready === 1'b1) begin
         if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
         else                   chk("data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
         exp_cnt++;
      end
   end

   task automatic load(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = base + 16'(i);
         exp_q.push_back(base + 16'(i));
         wr_ptr++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; drain_en = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data", {16'd0, m_data}, 32'd0);
      chk("rst_count", {16'd0, m_count}, 32'd0);
      chk("rst_err", {31'd0, err_underflow}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (k < budget && !(exp_q.size() == 0 && m_valid === 1'b0 && fifo_empty)) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int rd_n, v_n, first_rd, last_rd, first_v, last_v, stable_bad;
      rst_n = 1'b0; drain_en = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;

      // Reset then idle.
      do_reset();

      // Streaming: 8 preloaded words at full rate.
      load(8, 16'h0001);
      @(posedge clk); #1;
      drain_en = 1'b1; m_ready = 1'b1;
      rd_n = 0; v_n = 0; first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (fifo_rd_en) begin if (first_rd < 0) first_rd = c; last_rd = c; rd_n++; end
         if (m_valid)    begin if (first_v < 0) first_v = c; last_v = c; v_n++; end
      end
      chk("stream_rd_n", rd_n, 8);
      chk("stream_rd_span", last_rd - first_rd, 7);
      chk("stream_v_n", v_n, 8);
      chk("stream_v_span", last_v - first_v, 7);
      chk("first_word_lat_ok", {31'd0, (first_v - first_rd == 1) || (first_v - first_rd == 2)}, 32'd1);
      chk("stream_count", {16'd0, m_count}, 32'd8);
      chk("stream_sb_empty", exp_q.size(), 0);

      // Backpressure: m_ready low for 10 cycles.
      do_reset();
      load(8, 16'h0001);
      @(posedge clk); #1;
      drain_en = 1'b1;
      rd_n = 0; stable_bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_rd_en) rd_n++;
         if (m_valid && m_data !== 16'h0001) stable_bad++;
      end
      chk("bp_rd_n", rd_n, 2);
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_data", {16'd0, m_data}, 32'h0001);
      chk("bp_stable", stable_bad, 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      v_n = 0; first_v = -1; last_v = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (m_valid) begin if (first_v < 0) first_v = c; last_v = c; v_n++; end
      end
      chk("bp_first_v", first_v, 0);
      chk("bp_v_n", v_n, 8);
      chk("bp_v_span", last_v - first_v, 7);
      chk("bp_count", {16'd0, m_count}, 32'd8);

      // Alternating ready with a full FIFO.
      do_reset();
      load(8, 16'h0100);
      @(posedge clk); #1;
      drain_en = 1'b1;
      for (int c = 0; c < 30; c++) begin
         m_ready = ~m_ready;
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      wait_drain(40);
      chk("alt_count", {16'd0, m_count}, 32'd8);
      chk("alt_count_model", {16'd0, m_count}, exp_cnt);
      chk("alt_sb_empty", exp_q.size(), 0);

      // drain_en dropped the cycle after a read.
      do_reset();
      load(4, 16'h0200);
      @(posedge clk); #1;
      drain_en = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      chk("drn_first_rd", {31'd0, fifo_rd_en}, 32'd1);
      @(posedge clk); #1;
      drain_en = 1'b0;
      rd_n = 0; v_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (fifo_rd_en) rd_n++;
         if (m_valid) v_n++;
      end
      chk("drn_no_rd", rd_n, 0);
      chk("drn_inflight_out", v_n, 1);
      chk("drn_count1", {16'd0, m_count}, 32'd1);
      @(posedge clk); #1;
      drain_en = 1'b1;
      wait_drain(40);
      chk("drn_count", {16'd0, m_count}, 32'd4);

      // Injected underflow is sticky.
      @(posedge clk); #1;
      fifo_underflow = 1'b1;
      @(negedge clk);
      chk("uf_before", {31'd0, err_underflow}, 32'd0);
      @(posedge clk); #1;
      fifo_underflow = 1'b0;
      @(negedge clk);
      chk("uf_set", {31'd0, err_underflow}, 32'd1);
      repeat (5) @(negedge clk);
      chk("uf_hold", {31'd0, err_underflow}, 32'd1);

      // Mid-stream reset with a buffered word and one in flight.
      do_reset();
      load(8, 16'h0300);
      @(posedge clk); #1;
      drain_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_pre_valid", {31'd0, m_valid}, 32'd1);
      rst_n = 1'b0; drain_en = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_valid", {31'd0, m_valid}, 32'd0);
      chk("mid_data", {16'd0, m_data}, 32'd0);
      chk("mid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("mid_count", {16'd0, m_count}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      v_n = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (m_valid) v_n++;
      end
      chk("mid_discarded", v_n, 0);
      chk("mid_fifo_flushed", {31'd0, fifo_empty}, 32'd1);

      // Counter wrap on the 4-bit instance after 17 pops.
      do_reset();
      @(posedge clk); #1;
      drain_en = 1'b1; m_ready = 1'b1;
      load(8, 16'h0400);
      wait_drain(40);
      @(posedge clk); #1;
      load(8, 16'h0500);
      wait_drain(40);
      @(posedge clk); #1;
      load(1, 16'h0600);
      wait_drain(40);
      chk("wrap_count4", {28'd0, m_count4}, 32'd1);
      chk("wrap_count16", {16'd0, m_count}, 32'd17);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
